// File: rtl/assoc_cache_ctrl.sv
// Two-way set-associative cache controller with one LRU bit per set.
// Read hits complete in the request cycle; misses and writes wait on the SRAM controller.
module assoc_cache_ctrl #(
  parameter int DATA_W    = 32,
  parameter int OFFSET_W  = 1,
  parameter int INDEX_W   = 6,
  parameter int TAG_W     = 10,
  parameter int BASE_ADDR = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              MEM_R_EN,
  input  logic                              MEM_W_EN,
  input  logic [31:0]                       address,
  input  logic [DATA_W-1:0]                 wdata,
  input  logic                              flush,
  input  logic [(DATA_W << OFFSET_W)-1:0]   sram_rdata,
  input  logic                              sram_ready,
  output logic [31:0]                       sram_address,
  output logic [DATA_W-1:0]                 sram_wdata,
  output logic                              write_enb,
  output logic                              read_enb,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              ready,
  output logic [CNT_W-1:0]                  hit_count,
  output logic [CNT_W-1:0]                  miss_count,
  output logic [1:0]                        state_dbg
);

  localparam int LINE_W  = DATA_W << OFFSET_W;
  localparam int WORDS   = 1 << OFFSET_W;
  localparam int SETS    = 1 << INDEX_W;
  localparam int ADDR_HI = 2 + OFFSET_W + INDEX_W + TAG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, next_state;

  // Address decode relative to the cache window base.
  logic [31:0]         byte_off;
  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                unused_addr_bits;

  assign byte_off         = address - 32'(BASE_ADDR);
  assign offset           = byte_off[2 +: OFFSET_W];
  assign index            = byte_off[2 + OFFSET_W +: INDEX_W];
  assign tag              = byte_off[2 + OFFSET_W + INDEX_W +: TAG_W];
  assign unused_addr_bits = ^{byte_off[1:0], byte_off[31:ADDR_HI]};

  // Storage: per-way valid/tag/line, per-set LRU bit naming the victim way.
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [LINE_W-1:0] data_q  [2][SETS];

  logic              hit0, hit1, hit, hit_way, victim;
  logic [LINE_W-1:0] hit_line;

  assign hit0     = valid_q[0][index] && (tag_q[0][index] == tag);
  assign hit1     = valid_q[1][index] && (tag_q[1][index] == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit0 ? 1'b0 : 1'b1;
  assign hit_line = hit0 ? data_q[0][index] : data_q[1][index];
  assign victim   = lru_q[index];

  function automatic logic [DATA_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [OFFSET_W-1:0] off);
    word_sel = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (off == OFFSET_W'(i)) word_sel = line[i*DATA_W +: DATA_W];
    end
  endfunction

  function automatic logic [LINE_W-1:0] word_put(input logic [LINE_W-1:0] line,
                                                 input logic [OFFSET_W-1:0] off,
                                                 input logic [DATA_W-1:0] word);
    word_put = line;
    for (int i = 0; i < WORDS; i++) begin
      if (off == OFFSET_W'(i)) word_put[i*DATA_W +: DATA_W] = word;
    end
  endfunction

  // Processor/SRAM handshake: the processor holds address, wdata and the
  // enables stable until ready=1; the SRAM side holds read_enb/write_enb
  // until sram_ready=1, and the request completes in that same cycle.
  logic do_flush, do_touch, do_fill, do_wupd, inc_hit, inc_miss;

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    rdata      = '0;
    read_enb   = 1'b0;
    write_enb  = 1'b0;
    do_flush   = 1'b0;
    do_touch   = 1'b0;
    do_fill    = 1'b0;
    do_wupd    = 1'b0;
    inc_hit    = 1'b0;
    inc_miss   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (flush) begin
          do_flush = 1'b1;
          ready    = !(MEM_R_EN || MEM_W_EN);
        end else if (MEM_W_EN) begin
          ready      = 1'b0;
          next_state = WRITE;
        end else if (MEM_R_EN) begin
          if (hit) begin
            rdata    = word_sel(hit_line, offset);
            do_touch = 1'b1;
            inc_hit  = 1'b1;
          end else begin
            ready      = 1'b0;
            inc_miss   = 1'b1;
            next_state = MISS;
          end
        end
      end
      MISS: begin
        read_enb = 1'b1;
        ready    = sram_ready;
        if (sram_ready) begin
          rdata      = word_sel(sram_rdata, offset);
          do_fill    = 1'b1;
          next_state = IDLE;
        end
      end
      WRITE: begin
        write_enb = 1'b1;
        ready     = sram_ready;
        if (sram_ready) begin
          do_wupd    = hit;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (do_flush) begin
        valid_q[0] <= '0;
        valid_q[1] <= '0;
        lru_q      <= '0;
      end
      if (do_touch) lru_q[index] <= ~hit_way;
      if (do_fill) begin
        valid_q[victim][index] <= 1'b1;
        lru_q[index]           <= ~victim;
      end
      if (do_wupd) lru_q[index] <= ~hit_way;
      if (inc_hit && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
      if (inc_miss && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
    end
  end

  // Tag and line storage carry no reset; a reset-aborted operation must not write.
  always_ff @(posedge clk) begin
    if (!rst && do_fill) begin
      tag_q[victim][index]  <= tag;
      data_q[victim][index] <= sram_rdata;
    end
    if (!rst && do_wupd) begin
      data_q[hit_way][index] <= word_put(hit_line, offset, wdata);
    end
  end

  assign sram_address = address;
  assign sram_wdata   = wdata;
  assign state_dbg    = state;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Bench for assoc_cache_ctrl: directed vector table, hand-written reset/flush
// sequences and randomized traffic against a recency-ordered cache model.
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN, flush, sram_ready;
  logic [31:0] address, wdata;
  logic [63:0] sram_rdata;
  logic [31:0] sram_address, sram_wdata, rdata;
  logic        write_enb, read_enb, ready;
  logic [15:0] hit_count, miss_count;
  logic [1:0]  unused_state_dbg;

  int checks   = 0;
  int errors   = 0;
  int both_cnt = 0;
  logic [31:0] exp_q[$];

  assoc_cache_ctrl dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .wdata(wdata), .flush(flush),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .write_enb(write_enb), .read_enb(read_enb), .rdata(rdata), .ready(ready),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(unused_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; flush = 1'b0;
    sram_ready = 1'b0; address = 32'd1024; wdata = '0; sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Resident lines kept in one queue ordered by recency (MRU at the back);
  // a set holds at most two lines and evicts its least recently used one.
  typedef struct {
    int          idx;
    int          tag;
    logic [63:0] line;
  } ent_t;

  ent_t mdl_q[$];
  int   mdl_hits, mdl_misses;

  task automatic mdl_clear();
    mdl_q.delete();
  endtask

  task automatic decode(input logic [31:0] addr, output int off, output int idx, output int tag);
    longint w;
    w   = (longint'(addr) - 1024) / 4;
    off = int'(w % 2);
    idx = int'((w / 2) % 64);
    tag = int'((w / 128) % 1024);
  endtask

  task automatic mdl_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [63:0] line, output bit hit, output logic [31:0] data);
    int off, idx, tag, pos, n;
    ent_t e;
    decode(addr, off, idx, tag);
    pos = -1;
    data = '0;
    foreach (mdl_q[i]) if (mdl_q[i].idx == idx && mdl_q[i].tag == tag) pos = i;
    hit = (pos >= 0);
    if (hit) begin
      e = mdl_q[pos];
      mdl_q.delete(pos);
      if (wr) begin
        if (off == 1) e.line[63:32] = wd; else e.line[31:0] = wd;
      end else begin
        data = (off == 1) ? e.line[63:32] : e.line[31:0];
        if (mdl_hits < 65535) mdl_hits++;
      end
      mdl_q.push_back(e);
    end else if (!wr) begin
      if (mdl_misses < 65535) mdl_misses++;
      n = 0;
      foreach (mdl_q[i]) if (mdl_q[i].idx == idx) n++;
      if (n == 2) begin
        pos = -1;
        foreach (mdl_q[i]) if (mdl_q[i].idx == idx && pos < 0) pos = i;
        mdl_q.delete(pos);
      end
      e.idx = idx; e.tag = tag; e.line = line;
      mdl_q.push_back(e);
      data = (off == 1) ? line[63:32] : line[31:0];
    end
  endtask

  // ---------------- driver ----------------
  // Starts just after a rising edge; sram_ready rises once the request has
  // been outstanding for lat cycles. Returns cycles-to-ready (-1 on timeout).
  task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int lat, input logic [63:0] line, input bit flush_mid,
                     output int got_lat, output logic [31:0] got_rdata,
                     output int ren, output int wen);
    MEM_R_EN = !wr; MEM_W_EN = wr; address = addr; wdata = wd; sram_rdata = line;
    got_lat = -1; got_rdata = '0; ren = 0; wen = 0;
    for (int c = 0; c < 20; c++) begin
      sram_ready = (c >= lat);
      flush      = flush_mid && (c >= 1);
      @(negedge clk);
      if (c == 0) begin
        check("sram_address", 64'(sram_address), 64'(addr));
        check("sram_wdata", 64'(sram_wdata), 64'(wd));
      end
      if (read_enb) ren++;
      if (write_enb) wen++;
      if (read_enb && write_enb) both_cnt++;
      if (ready) begin
        got_lat = c;
        got_rdata = rdata;
      end
      @(posedge clk);
      #1;
      if (got_lat >= 0) break;
    end
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; flush = 1'b0; sram_ready = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic [63:0] line;
    int          exp_lat;
    logic [31:0] exp_rdata;
    int          exp_ren;
    int          exp_wen;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat, input logic [63:0] line,
                         input int exp_lat, input logic [31:0] exp_rdata, input int exp_ren,
                         input int exp_wen, input int exp_hits, input int exp_misses);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.wd = wd; v.lat = lat; v.line = line;
    v.exp_lat = exp_lat; v.exp_rdata = exp_rdata; v.exp_ren = exp_ren; v.exp_wen = exp_wen;
    v.exp_hits = exp_hits; v.exp_misses = exp_misses;
    vecs.push_back(v);
  endtask

  task automatic run_random(input int n);
    bit          wr, hit;
    int          got_lat, ren, wen, exp_lat;
    logic [31:0] addr, wd, got_rd, exp_rd, model_rd;
    logic [63:0] line;
    int          lat;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        check("rnd_flush_ready", 64'(ready), 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        mdl_clear();
      end else begin
        wr   = ($urandom_range(0, 3) == 0);
        addr = 32'(1024 + $urandom_range(0, 3) * 512 + $urandom_range(0, 3) * 8 +
                   $urandom_range(0, 1) * 4);
        lat  = $urandom_range(1, 3);
        line = {$urandom, $urandom};
        wd   = $urandom;
        mdl_access(wr, addr, wd, line, hit, model_rd);
        if (!wr) exp_q.push_back(model_rd);
        req(wr, addr, wd, lat, line, 1'b0, got_lat, got_rd, ren, wen);
        exp_lat = (!wr && hit) ? 0 : lat;
        check("rnd_latency", 64'(got_lat), 64'(exp_lat));
        if (!wr) begin
          exp_rd = exp_q.pop_front();
          check("rnd_rdata", 64'(got_rd), 64'(exp_rd));
        end
        check("rnd_read_enb_cycles", 64'(ren), 64'((!wr && !hit) ? lat : 0));
        check("rnd_write_enb_cycles", 64'(wen), 64'(wr ? lat : 0));
        check("rnd_hit_count", 64'(hit_count), 64'(mdl_hits));
        check("rnd_miss_count", 64'(miss_count), 64'(mdl_misses));
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          got_lat, ren, wen;
    logic [31:0] got_rd;

    do_reset();
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_read_enb", 64'(read_enb), 64'd0);
    check("reset_write_enb", 64'(write_enb), 64'd0);
    check("reset_hit_count", 64'(hit_count), 64'd0);
    check("reset_miss_count", 64'(miss_count), 64'd0);
    @(posedge clk);
    #1;

    add_vec("cold_read",      0, 1024, 0, 3, 64'hBBBB_BBBB_AAAA_AAAA, 3, 32'hAAAA_AAAA, 3, 0, 0, 1);
    add_vec("same_line_hit",  0, 1028, 0, 3, 64'h0,                   0, 32'hBBBB_BBBB, 0, 0, 1, 1);
    add_vec("fill_way1",      0, 1536, 0, 1, 64'h2222_2222_1111_1111, 1, 32'h1111_1111, 1, 0, 1, 2);
    add_vec("touch_1024",     0, 1024, 0, 1, 64'h0,                   0, 32'hAAAA_AAAA, 0, 0, 2, 2);
    add_vec("conflict_2048",  0, 2048, 0, 2, 64'h4444_4444_3333_3333, 2, 32'h3333_3333, 2, 0, 2, 3);
    add_vec("kept_1024",      0, 1024, 0, 1, 64'h0,                   0, 32'hAAAA_AAAA, 0, 0, 3, 3);
    add_vec("evicted_1536",   0, 1536, 0, 1, 64'h2222_2222_1111_1111, 1, 32'h1111_1111, 1, 0, 3, 4);
    add_vec("write_hit",      1, 1024, 32'h1234_5678, 2, 64'h0,       2, 32'h0,         0, 2, 3, 4);
    add_vec("read_written",   0, 1024, 0, 1, 64'h0,                   0, 32'h1234_5678, 0, 0, 4, 4);
    add_vec("other_word",     0, 1028, 0, 1, 64'h0,                   0, 32'hBBBB_BBBB, 0, 0, 5, 4);
    add_vec("write_unmapped", 1, 3072, 32'hDEAD_BEEF, 1, 64'h0,       1, 32'h0,         0, 1, 5, 4);
    add_vec("unmapped_miss",  0, 3072, 0, 1, 64'h6666_6666_5555_5555, 1, 32'h5555_5555, 1, 0, 5, 5);

    foreach (vecs[i]) begin
      req(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].lat, vecs[i].line, 1'b0,
          got_lat, got_rd, ren, wen);
      check({vecs[i].name, "_latency"}, 64'(got_lat), 64'(vecs[i].exp_lat));
      if (!vecs[i].wr) check({vecs[i].name, "_rdata"}, 64'(got_rd), 64'(vecs[i].exp_rdata));
      check({vecs[i].name, "_read_enb"}, 64'(ren), 64'(vecs[i].exp_ren));
      check({vecs[i].name, "_write_enb"}, 64'(wen), 64'(vecs[i].exp_wen));
      check({vecs[i].name, "_hits"}, 64'(hit_count), 64'(vecs[i].exp_hits));
      check({vecs[i].name, "_misses"}, 64'(miss_count), 64'(vecs[i].exp_misses));
    end

    // Flush alone in IDLE, then a read that must miss.
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    req(0, 1024, 0, 1, 64'h7777_7777_CCCC_CCCC, 1'b0, got_lat, got_rd, ren, wen);
    check("flush_read_latency", 64'(got_lat), 64'd1);
    check("flush_read_rdata", 64'(got_rd), 64'hCCCC_CCCC);
    check("flush_read_misses", 64'(miss_count), 64'd6);

    // Flush with a read pending: ready low that cycle, line gone afterwards.
    flush = 1'b1; MEM_R_EN = 1'b1; address = 1024;
    @(negedge clk);
    check("flush_pending_ready", 64'(ready), 64'd0);
    check("flush_pending_read_enb", 64'(read_enb), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    req(0, 1024, 0, 1, 64'h7777_7777_CCCC_CCCC, 1'b0, got_lat, got_rd, ren, wen);
    check("flush_pending_then_miss", 64'(got_lat), 64'd1);
    check("flush_pending_misses", 64'(miss_count), 64'd7);

    // Flush during MISS must be ignored: the fill survives.
    req(0, 1536, 0, 2, 64'h9999_9999_8888_8888, 1'b1, got_lat, got_rd, ren, wen);
    check("flush_in_miss_latency", 64'(got_lat), 64'd2);
    req(0, 1540, 0, 1, 64'h0, 1'b0, got_lat, got_rd, ren, wen);
    check("flush_in_miss_hit", 64'(got_lat), 64'd0);
    check("flush_in_miss_rdata", 64'(got_rd), 64'h9999_9999);
    check("flush_in_miss_hits", 64'(hit_count), 64'd6);

    // Reset while in MISS with sram_ready high: no fill, counters cleared.
    MEM_R_EN = 1'b1; address = 4096; sram_ready = 1'b0;
    @(negedge clk);
    check("rst_miss_idle_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_miss_read_enb", 64'(read_enb), 64'd1);
    rst = 1'b1; sram_ready = 1'b1; sram_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
    @(posedge clk);
    #1 rst = 1'b0; MEM_R_EN = 1'b0; sram_ready = 1'b0;
    @(negedge clk);
    check("rst_miss_read_enb_after", 64'(read_enb), 64'd0);
    check("rst_miss_write_enb_after", 64'(write_enb), 64'd0);
    check("rst_miss_ready_after", 64'(ready), 64'd1);
    check("rst_miss_hits", 64'(hit_count), 64'd0);
    check("rst_miss_misses", 64'(miss_count), 64'd0);
    @(posedge clk);
    #1;
    req(0, 4096, 0, 1, 64'h0, 1'b0, got_lat, got_rd, ren, wen);
    check("rst_miss_no_fill", 64'(got_lat), 64'd1);
    req(0, 1536, 0, 1, 64'h0, 1'b0, got_lat, got_rd, ren, wen);
    check("rst_miss_no_valid", 64'(got_lat), 64'd1);
    check("rst_miss_recount", 64'(miss_count), 64'd2);

    // Reset while in WRITE with sram_ready high: no update, line invalidated.
    req(0, 1024, 0, 1, 64'h1111_0000_2222_0000, 1'b0, got_lat, got_rd, ren, wen);
    MEM_W_EN = 1'b1; address = 1024; wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check("rst_write_idle_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_write_write_enb", 64'(write_enb), 64'd1);
    rst = 1'b1; sram_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    @(negedge clk);
    check("rst_write_write_enb_after", 64'(write_enb), 64'd0);
    check("rst_write_read_enb_after", 64'(read_enb), 64'd0);
    @(posedge clk);
    #1;
    req(0, 1024, 0, 1, 64'h3333_0000_4444_0000, 1'b0, got_lat, got_rd, ren, wen);
    check("rst_write_miss", 64'(got_lat), 64'd1);
    check("rst_write_rdata", 64'(got_rd), 64'h4444_0000);

    // Randomized traffic against the model from a clean reset.
    do_reset();
    mdl_clear();
    mdl_hits = 0;
    mdl_misses = 0;
    run_random(400);

    check("no_dual_strobe", 64'(both_cnt), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
